rx_frame_arbiter: RTL and testbench
===================================

Name: rx_frame_arbiter

Overview:
- Frame-granular round-robin arbiter between the PHY_NUM per-port RX packet FIFOs and the single MAC decoder ingress.
- Holds a grant for a whole frame, which ends at the FIFO's EOD mark, so frames are never interleaved.
- Truncates runaway frames that exceed MAX_LEN bytes and counts the aborts.
- Sits in the system clock domain, on the read side of the RX FIFOs.

Parameters:
- PHY_NUM, 4, number of requesting RX FIFOs (2..8).
- MAX_LEN, 1518, maximum bytes per frame before truncation.
- PTR_W, 2, width of the port index; must satisfy 2**PTR_W >= PHY_NUM.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  PHY_NUM  per-port RX FIFO empty flags.
- fifo_dout  in  8*PHY_NUM  per-port FIFO read data; port p occupies bits [8p+7:8p].
- fifo_eod  in  PHY_NUM  per-port EOD_out; marks the last byte of a frame.
- fifo_rden  out  PHY_NUM  per-port read enable; one-hot or zero.
- out_ready  in  1  downstream can accept a byte (not almost-full).
- out_data  out  8  forwarded byte.
- out_valid  out  1  out_data is valid this cycle.
- out_sof  out  1  first byte of a frame, qualified by out_valid.
- out_eod  out  1  last byte of a frame, qualified by out_valid.
- out_abort  out  1  one-cycle pulse: the current frame was truncated.
- out_port  out  PTR_W  index of the granted port; stable while busy.
- busy  out  1  a grant is held.
- abort_cnt  out  16  number of truncated frames; saturates at 0xFFFF.

Behaviour:
- FIFO read timing: fifo_rden high in cycle t gives valid fifo_dout and fifo_eod in cycle t+1.
- At most one read is outstanding at a time. Peak rate is one byte per 2 clk cycles, which is ample for 10 Mb/s ports.
- States: IDLE, RD, WT, FLUSH_RD, FLUSH_WT, GAP.
- Reset values:
  - state is IDLE.
  - All outputs are 0.
  - last_ptr is PHY_NUM-1, so port 0 has first priority.
  - byte_cnt is 0.
- IDLE:
  - The request vector is ~fifo_empty.
  - If any request is set, grant the first requesting port searching from last_ptr+1 and wrapping modulo PHY_NUM.
  - On a grant: latch out_port, set busy, clear byte_cnt, set the sof_pending flag, and go to RD in the next cycle.
  - Grant decision latency is 1 cycle.
- RD:
  - If the granted FIFO is not empty and out_ready is high, assert fifo_rden[out_port] for exactly 1 cycle and go to WT.
  - Otherwise stall in RD indefinitely. Underrun is not an error.
- WT:
  - out_data = the granted slice of fifo_dout, out_valid = 1, out_eod = fifo_eod[out_port], out_sof = sof_pending.
  - Clear sof_pending and increment byte_cnt.
  - If eod is set, go to GAP.
  - Else if the incremented byte_cnt == MAX_LEN, go to FLUSH_RD.
  - Else go to RD.
- FLUSH_RD / FLUSH_WT:
  - Drain the granted FIFO with the same single-outstanding read rule.
  - out_ready is ignored and out_valid stays 0.
  - When the returned byte carries eod: pulse out_abort, increment abort_cnt (saturating), and go to GAP.
- GAP:
  - Set last_ptr = out_port and clear busy.
  - Return to IDLE; the new arbitration happens in IDLE on the next cycle.
- Boundary conditions:
  - A byte with eod that arrives exactly at byte MAX_LEN is a normal frame end: no abort, and out_eod = 1.
  - Requests from ungranted ports never preempt the current grant.
  - Simultaneous requests from all ports are served strictly in rotation.
  - A lone requester is re-granted after each GAP.
  - out_ready falling while in WT does not drop the byte: the byte is presented regardless. out_ready only gates the next read issued in RD.
- Reset mid-frame:
  - Return to IDLE immediately and drop the partial frame with no out_eod or out_abort.
  - abort_cnt clears to 0.
  - The RX FIFOs are reset by the same rst, so no residue remains.

Test Plan:
1. Port 2 only, 64-byte frame, out_ready = 1 → out_port = 2, exactly 64 out_valid beats spaced 2 cycles apart, out_sof on beat 1, out_eod on beat 64, abort_cnt = 0.
2. All four ports each hold two 60-byte frames → grant order is 0,1,2,3,0,1,2,3, with no byte interleaving between frames.
3. out_ready held low for 10 cycles mid-frame on port 1 → no fifo_rden during the hold, no byte lost or duplicated, and the byte sequence matches the source.
4. Port 3 frame of 1600 bytes with MAX_LEN = 1518 → 1518 out_valid beats with no out_eod, 82 bytes drained silently, a single out_abort pulse, abort_cnt = 1, then port 0 is served next.
5. Frame of exactly 1518 bytes → out_eod on beat 1518, no out_abort.
6. rst asserted for 1 cycle at byte 30 of a port 1 frame → all outputs are 0 in the following cycle, state is IDLE, last_ptr = PHY_NUM-1, and the next grant goes to the lowest requesting port.

Source files
------------

// File: rtl/rx_frame_arbiter.sv
// Frame-granular round-robin arbiter from PHY_NUM RX packet FIFOs into the MAC decoder ingress.
// One FIFO read is in flight at a time. Frames longer than MAX_LEN are truncated, drained and counted.
module rx_frame_arbiter #(
  parameter int PHY_NUM = 4,
  parameter int MAX_LEN = 1518,
  parameter int PTR_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PHY_NUM-1:0]   fifo_empty,
  input  logic [8*PHY_NUM-1:0] fifo_dout,
  input  logic [PHY_NUM-1:0]   fifo_eod,
  output logic [PHY_NUM-1:0]   fifo_rden,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  output logic                 out_sof,
  output logic                 out_eod,
  output logic                 out_abort,
  output logic [PTR_W-1:0]     out_port,
  output logic                 busy,
  output logic [15:0]          abort_cnt
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WT,
    FLUSH_RD,
    FLUSH_WT,
    GAP
  } state_t;

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] port_reg, port_next;
  logic [PTR_W-1:0] last_ptr_reg, last_ptr_next;
  logic             busy_reg, busy_next;
  logic             sof_pending_reg, sof_pending_next;
  logic [CNT_W-1:0] byte_cnt_reg, byte_cnt_next;
  logic [CNT_W-1:0] byte_inc;
  logic [15:0]      abort_cnt_reg, abort_cnt_next;

  logic [7:0]       dout_arr [PHY_NUM];
  logic [PTR_W-1:0] cand_idx [PHY_NUM];
  logic [PHY_NUM-1:0] cand_req;
  logic             grant_any;
  logic [PTR_W-1:0] grant_idx;
  logic             cur_empty;
  logic             cur_eod;
  logic [7:0]       cur_dout;

  genvar gi;
  generate
    for (gi = 0; gi < PHY_NUM; gi++) begin : g_port
      assign dout_arr[gi] = fifo_dout[8*gi +: 8];
    end

    // Candidate gi is the port gi+1 places after last_ptr, wrapped modulo PHY_NUM.
    for (gi = 0; gi < PHY_NUM; gi++) begin : g_rr
      logic [PTR_W:0] rr_sum;
      assign rr_sum = {1'b0, last_ptr_reg} + (PTR_W+1)'(gi + 1);
      assign cand_idx[gi] = (rr_sum >= (PTR_W+1)'(PHY_NUM))
                          ? PTR_W'(rr_sum - (PTR_W+1)'(PHY_NUM))
                          : rr_sum[PTR_W-1:0];
      assign cand_req[gi] = ~fifo_empty[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = PHY_NUM - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx[k];
      end
    end
  end

  assign cur_empty = fifo_empty[port_reg];
  assign cur_eod   = fifo_eod[port_reg];
  assign cur_dout  = dout_arr[port_reg];
  assign byte_inc  = byte_cnt_reg + CNT_W'(1);

  always_comb begin
    state_next       = state_reg;
    port_next        = port_reg;
    last_ptr_next    = last_ptr_reg;
    busy_next        = busy_reg;
    sof_pending_next = sof_pending_reg;
    byte_cnt_next    = byte_cnt_reg;
    abort_cnt_next   = abort_cnt_reg;
    fifo_rden        = '0;
    out_data         = 8'h00;
    out_valid        = 1'b0;
    out_sof          = 1'b0;
    out_eod          = 1'b0;
    out_abort        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (grant_any) begin
          port_next        = grant_idx;
          busy_next        = 1'b1;
          byte_cnt_next    = '0;
          sof_pending_next = 1'b1;
          state_next       = RD;
        end
      end

      RD: begin
        if (!cur_empty && out_ready) begin
          fifo_rden[port_reg] = 1'b1;
          state_next          = WT;
        end
      end

      // The byte requested in RD is presented here whatever out_ready does now.
      WT: begin
        out_data         = cur_dout;
        out_valid        = 1'b1;
        out_eod          = cur_eod;
        out_sof          = sof_pending_reg;
        sof_pending_next = 1'b0;
        byte_cnt_next    = byte_inc;
        if (cur_eod) begin
          state_next = GAP;
        end else if (byte_inc == CNT_W'(MAX_LEN)) begin
          state_next = FLUSH_RD;
        end else begin
          state_next = RD;
        end
      end

      FLUSH_RD: begin
        if (!cur_empty) begin
          fifo_rden[port_reg] = 1'b1;
          state_next          = FLUSH_WT;
        end
      end

      FLUSH_WT: begin
        if (cur_eod) begin
          out_abort = 1'b1;
          if (abort_cnt_reg != 16'hFFFF) begin
            abort_cnt_next = abort_cnt_reg + 16'd1;
          end
          state_next = GAP;
        end else begin
          state_next = FLUSH_RD;
        end
      end

      GAP: begin
        last_ptr_next = port_reg;
        busy_next     = 1'b0;
        state_next    = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      port_reg        <= '0;
      last_ptr_reg    <= PTR_W'(PHY_NUM - 1);
      busy_reg        <= 1'b0;
      sof_pending_reg <= 1'b0;
      byte_cnt_reg    <= '0;
      abort_cnt_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      port_reg        <= port_next;
      last_ptr_reg    <= last_ptr_next;
      busy_reg        <= busy_next;
      sof_pending_reg <= sof_pending_next;
      byte_cnt_reg    <= byte_cnt_next;
      abort_cnt_reg   <= abort_cnt_next;
    end
  end

  assign out_port  = port_reg;
  assign busy      = busy_reg;
  assign abort_cnt = abort_cnt_reg;

endmodule

// File: tb/tb_rx_frame_arbiter.sv
// Directed bench for rx_frame_arbiter: behavioural RX FIFOs with one-cycle read latency,
// a capture of every forwarded byte, and immediate-assertion checks against hand-built frames.
module tb_rx_frame_arbiter;

  localparam int NP = 4;
  localparam int ML = 1518;

  logic            clk;
  logic            rst;
  logic [NP-1:0]   fifo_empty;
  logic [8*NP-1:0] fifo_dout;
  logic [NP-1:0]   fifo_eod;
  logic [NP-1:0]   fifo_rden;
  logic            out_ready;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_sof;
  logic            out_eod;
  logic            out_abort;
  logic [1:0]      out_port;
  logic            busy;
  logic [15:0]     abort_cnt;

  rx_frame_arbiter #(.PHY_NUM(NP), .MAX_LEN(ML), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_eod(fifo_eod),
    .fifo_rden(fifo_rden), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof),
    .out_eod(out_eod), .out_abort(out_abort), .out_port(out_port),
    .busy(busy), .abort_cnt(abort_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-port FIFO storage: {eod, byte}
  logic [8:0] mem [NP][4096];
  int wr_p [NP];
  int rd_p [NP];
  int pop_cnt [NP];

  logic [7:0] cap_data [8192];
  logic       cap_sof  [8192];
  logic       cap_eod  [8192];
  logic [1:0] cap_port [8192];
  int         cap_cyc  [8192];
  int         cap_n;

  int n_cmp, n_err;
  int n_abort, n_rden_low, n_multi, n_underrun, cyc;
  logic [NP-1:0] rden_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int p, input int len, input int base);
    for (int i = 0; i < len; i++) begin
      mem[p][wr_p[p]] = {(i == len - 1), 8'(base + i)};
      wr_p[p]++;
    end
    fifo_empty[p] = 1'b0;
  endtask

  // Sample just after inputs settle, then model the FIFO reads at the next edge.
  task automatic tick();
    #1;
    if (out_valid) begin
      cap_data[cap_n] = out_data;
      cap_sof[cap_n]  = out_sof;
      cap_eod[cap_n]  = out_eod;
      cap_port[cap_n] = out_port;
      cap_cyc[cap_n]  = cyc;
      if (cap_n < 8191) cap_n++;
    end
    if (out_abort) n_abort++;
    if (fifo_rden != '0 && !out_ready) n_rden_low++;
    if ($countones(fifo_rden) > 1) n_multi++;
    rden_s = fifo_rden;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (rst) begin
        rd_p[p] = wr_p[p];
        fifo_dout[8*p +: 8] = 8'h00;
        fifo_eod[p] = 1'b0;
      end else if (rden_s[p]) begin
        if (rd_p[p] == wr_p[p]) begin
          n_underrun++;
        end else begin
          {fifo_eod[p], fifo_dout[8*p +: 8]} = mem[p][rd_p[p]];
          rd_p[p]++;
          pop_cnt[p]++;
        end
      end
      fifo_empty[p] = (rd_p[p] == wr_p[p]);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_done(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      tick();
      if (fifo_empty == '1 && !busy) done = 1'b1;
    end
    check({tag, " done"}, 32'(done), 32'd1);
  endtask

  task automatic run_until_beats(input string tag, input int beats, input int budget);
    for (int n = 0; n < budget && cap_n < beats; n++) tick();
    check({tag, " reached"}, 32'(cap_n >= beats), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int start, input int p, input int len,
                             input int base, input bit has_eod);
    int errs;
    logic [7:0] e;
    errs = 0;
    for (int i = 0; i < len; i++) begin
      e = 8'(base + i);
      if (start + i >= cap_n) begin
        errs++;
      end else begin
        if (cap_data[start+i] !== e) errs++;
        if (cap_port[start+i] !== 2'(p)) errs++;
        if (cap_sof[start+i] !== (i == 0)) errs++;
        if (cap_eod[start+i] !== (has_eod && i == len - 1)) errs++;
      end
    end
    $display("frame %s: port=%0d len=%0d base=%02h eod=%0d", tag, p, len, base, has_eod);
    check({tag, " port"}, (start < cap_n) ? 32'(cap_port[start]) : 32'hDEAD, 32'(p));
    check({tag, " bytes"}, 32'(errs), 32'd0);
  endtask

  initial begin
    int gaps;
    n_cmp = 0; n_err = 0; n_abort = 0; n_rden_low = 0; n_multi = 0; n_underrun = 0;
    cyc = 0; cap_n = 0;
    for (int p = 0; p < NP; p++) begin
      wr_p[p] = 0; rd_p[p] = 0; pop_cnt[p] = 0;
    end
    rst = 1'b1; out_ready = 1'b1;
    fifo_empty = '1; fifo_dout = '0; fifo_eod = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst out_valid", 32'(out_valid), 0);
    check("rst out_sof", 32'(out_sof), 0);
    check("rst out_eod", 32'(out_eod), 0);
    check("rst out_abort", 32'(out_abort), 0);
    check("rst out_data", 32'(out_data), 0);
    check("rst fifo_rden", 32'(fifo_rden), 0);
    check("rst busy", 32'(busy), 0);
    check("rst out_port", 32'(out_port), 0);
    check("rst abort_cnt", 32'(abort_cnt), 0);

    // 1: lone 64-byte frame on port 2
    cap_n = 0;
    push_frame(2, 64, 8'h10);
    run_until_done("t1", 1000);
    check("t1 beats", 32'(cap_n), 64);
    check_frame("t1", 0, 2, 64, 8'h10, 1'b1);
    gaps = 0;
    for (int i = 1; i < cap_n; i++) if (cap_cyc[i] - cap_cyc[i-1] != 2) gaps++;
    check("t1 spacing", 32'(gaps), 0);
    check("t1 abort_cnt", 32'(abort_cnt), 0);

    // 2: all ports, two frames each, after a fresh reset so port 0 leads
    rst = 1'b1; tick(); rst = 1'b0;
    cap_n = 0;
    for (int p = 0; p < NP; p++) begin
      push_frame(p, 60, p * 32);
      push_frame(p, 60, p * 32 + 128);
    end
    run_until_done("t2", 3000);
    check("t2 beats", 32'(cap_n), 480);
    for (int f = 0; f < 8; f++) begin
      check_frame($sformatf("t2 f%0d", f), f * 60, f % 4, 60, (f % 4) * 32 + (f / 4) * 128, 1'b1);
    end

    // 3: out_ready low for 10 cycles mid-frame on port 1
    cap_n = 0;
    push_frame(1, 40, 8'h55);
    run_until_beats("t3", 15, 200);
    out_ready = 1'b0;
    n_rden_low = 0;
    repeat (10) tick();
    check("t3 rden during hold", 32'(n_rden_low), 0);
    check("t3 beats frozen", 32'(cap_n <= 16), 1);
    out_ready = 1'b1;
    run_until_done("t3", 500);
    check("t3 beats", 32'(cap_n), 40);
    check_frame("t3", 0, 1, 40, 8'h55, 1'b1);

    // 4: runaway frame on port 3, port 0 waiting
    cap_n = 0; n_abort = 0;
    pop_cnt[3] = 0;
    push_frame(3, 1600, 8'h30);
    push_frame(0, 20, 8'h90);
    run_until_done("t4", 8000);
    check("t4 beats", 32'(cap_n), 1538);
    check_frame("t4 trunc", 0, 3, ML, 8'h30, 1'b0);
    check("t4 drained", 32'(pop_cnt[3]), 1600);
    check("t4 abort pulses", 32'(n_abort), 1);
    check("t4 abort_cnt", 32'(abort_cnt), 1);
    check_frame("t4 next", ML, 0, 20, 8'h90, 1'b1);

    // 5: frame of exactly MAX_LEN bytes ends normally
    cap_n = 0; n_abort = 0;
    push_frame(1, ML, 8'h11);
    run_until_done("t5", 8000);
    check("t5 beats", 32'(cap_n), ML);
    check_frame("t5", 0, 1, ML, 8'h11, 1'b1);
    check("t5 abort pulses", 32'(n_abort), 0);
    check("t5 abort_cnt", 32'(abort_cnt), 1);

    // 6: reset at byte 30 of a port 1 frame
    cap_n = 0; n_abort = 0;
    push_frame(1, 100, 8'h40);
    run_until_beats("t6", 30, 200);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6 out_valid", 32'(out_valid), 0);
    check("t6 out_eod", 32'(out_eod), 0);
    check("t6 out_abort", 32'(out_abort), 0);
    check("t6 fifo_rden", 32'(fifo_rden), 0);
    check("t6 busy", 32'(busy), 0);
    check("t6 out_port", 32'(out_port), 0);
    check("t6 abort_cnt", 32'(abort_cnt), 0);
    check("t6 partial eod", 32'(cap_n > 0 && cap_eod[cap_n-1]), 0);
    check("t6 abort pulses", 32'(n_abort), 0);
    cap_n = 0;
    push_frame(3, 10, 8'hA0);
    push_frame(1, 10, 8'hB0);
    run_until_done("t6b", 500);
    check("t6b beats", 32'(cap_n), 20);
    check_frame("t6b first", 0, 1, 10, 8'hB0, 1'b1);
    check_frame("t6b second", 10, 3, 10, 8'hA0, 1'b1);

    check("rden one-hot", 32'(n_multi), 0);
    check("no underrun reads", 32'(n_underrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
